// File: rtl/countdown_alarm_ctrl_pkg.sv
// Shared definitions for the MM:SS countdown alarm timer: FSM states,
// the blank digit code and BCD digit limits.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_CODE   = 4'hF;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] UNITS_MAX    = 4'd9;

endpackage

// File: rtl/bcd_mod60_updown.sv
// Two-digit BCD modulo-60 counter (00..59) with increment, decrement and
// synchronous clear; exposes its next value so the owner can register outputs.
module bcd_mod60_updown
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic [3:0] nxt_tens,
    output logic [3:0] nxt_units,
    output logic       borrow
);

    // borrow flags a decrement from 00 that wraps to 59
    assign borrow = dec && !inc && (tens == 4'd0) && (units == 4'd0);

    always_comb begin
        nxt_tens  = tens;
        nxt_units = units;
        if (clr) begin
            nxt_tens  = '0;
            nxt_units = '0;
        end else if (inc && !dec) begin
            if (units == UNITS_MAX) begin
                nxt_units = '0;
                nxt_tens  = (tens == SEC_TENS_MAX) ? 4'd0 : tens + 4'd1;
            end else begin
                nxt_units = units + 4'd1;
            end
        end else if (dec && !inc) begin
            if (units == 4'd0) begin
                nxt_units = UNITS_MAX;
                nxt_tens  = (tens == 4'd0) ? SEC_TENS_MAX : tens - 4'd1;
            end else begin
                nxt_units = units - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens  <= '0;
            units <= '0;
        end else begin
            tens  <= nxt_tens;
            units <= nxt_units;
        end
    end

endmodule

// File: rtl/countdown_alarm_ctrl.sv
// MM:SS countdown timer with alarm: button-loaded BCD time, 1 Hz decrement,
// flashing alarm display and registered seven-segment digit codes.
module countdown_alarm_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned ALARM_TICKS = 10,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       set_min,
    input  logic       set_sec,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] dig3,
    output logic [3:0] dig2,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic       running,
    output logic       alarm
);

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);
    localparam logic [3:0] DIG3_RST   = LZ_BLANK ? BLANK_CODE : 4'd0;

    state_t     state, state_nxt;
    logic       flash, flash_nxt;
    logic [7:0] alarm_cnt, alarm_cnt_nxt;

    logic       time_clr, min_inc, sec_inc, sec_dec;
    logic       sec_borrow, min_borrow;
    logic [3:0] m_t, m_u, s_t, s_u;
    logic [3:0] m_t_nxt, m_u_nxt, s_t_nxt, s_u_nxt;
    logic       time_zero, last_second, blank_all;

    bcd_mod60_updown u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (time_clr),
        .inc      (min_inc),
        .dec      (sec_borrow),
        .tens     (m_t),
        .units    (m_u),
        .nxt_tens (m_t_nxt),
        .nxt_units(m_u_nxt),
        .borrow   (min_borrow)
    );

    bcd_mod60_updown u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (time_clr),
        .inc      (sec_inc),
        .dec      (sec_dec),
        .tens     (s_t),
        .units    (s_u),
        .nxt_tens (s_t_nxt),
        .nxt_units(s_u_nxt),
        .borrow   (sec_borrow)
    );

    assign time_zero   = (m_t == 4'd0) && (m_u == 4'd0) && (s_t == 4'd0) && (s_u == 4'd0);
    assign last_second = (m_t == 4'd0) && (m_u == 4'd0) && (s_t == 4'd0) && (s_u == 4'd1);

    always_comb begin
        state_nxt     = state;
        flash_nxt     = flash;
        alarm_cnt_nxt = alarm_cnt;
        time_clr      = 1'b0;
        min_inc       = 1'b0;
        sec_inc       = 1'b0;
        sec_dec       = 1'b0;
        if (clear) begin
            state_nxt     = IDLE;
            time_clr      = 1'b1;
            flash_nxt     = 1'b0;
            alarm_cnt_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_stop) begin
                        if (!time_zero) state_nxt = RUN;
                    end else begin
                        min_inc = set_min;
                        sec_inc = set_sec;
                    end
                end
                RUN: begin
                    if (tick) begin
                        sec_dec = 1'b1;
                        // an underflow from 00:00 cannot occur in RUN; treat it as expiry too
                        if (last_second || min_borrow) begin
                            state_nxt     = ALARM;
                            flash_nxt     = 1'b0;
                            alarm_cnt_nxt = '0;
                        end else if (start_stop) begin
                            state_nxt = PAUSE;
                        end
                    end else if (start_stop) begin
                        state_nxt = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state_nxt = time_zero ? IDLE : RUN;
                    end else begin
                        min_inc = set_min;
                        sec_inc = set_sec;
                    end
                end
                ALARM: begin
                    if (start_stop || (tick && alarm_cnt == ALARM_LAST)) begin
                        state_nxt     = IDLE;
                        flash_nxt     = 1'b0;
                        alarm_cnt_nxt = '0;
                    end else if (tick) begin
                        flash_nxt     = !flash;
                        alarm_cnt_nxt = alarm_cnt + 8'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign blank_all = (state_nxt == ALARM) && flash_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flash     <= 1'b0;
            alarm_cnt <= '0;
            running   <= 1'b0;
            alarm     <= 1'b0;
            dig3      <= DIG3_RST;
            dig2      <= '0;
            dig1      <= '0;
            dig0      <= '0;
        end else begin
            state     <= state_nxt;
            flash     <= flash_nxt;
            alarm_cnt <= alarm_cnt_nxt;
            running   <= (state_nxt == RUN);
            alarm     <= (state_nxt == ALARM);
            dig3      <= (blank_all || (LZ_BLANK && m_t_nxt == 4'd0)) ? BLANK_CODE : m_t_nxt;
            dig2      <= blank_all ? BLANK_CODE : m_u_nxt;
            dig1      <= blank_all ? BLANK_CODE : s_t_nxt;
            dig0      <= blank_all ? BLANK_CODE : s_u_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_alarm_ctrl.sv
// Self-checking bench for countdown_alarm_ctrl: directed scenarios plus a
// randomized run against a seconds-count reference model.
module tb_countdown_alarm_ctrl;

    localparam int ALARM_TICKS = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, set_min = 1'b0, set_sec = 1'b0, start_stop = 1'b0, clear = 1'b0;
    logic [3:0] dig3, dig2, dig1, dig0;
    logic       running, alarm;

    int errors = 0;
    int checks = 0;

    // reference model: minutes, seconds, mode (0 idle, 1 counting, 2 paused, 3 ringing)
    int mdl_min, mdl_sec, mdl_mode, mdl_acnt;
    bit mdl_flash;

    countdown_alarm_ctrl #(.ALARM_TICKS(ALARM_TICKS), .LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .set_min(set_min), .set_sec(set_sec),
        .start_stop(start_stop), .clear(clear), .dig3(dig3), .dig2(dig2), .dig1(dig1),
        .dig0(dig0), .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mdl_min = 0; mdl_sec = 0; mdl_mode = 0; mdl_acnt = 0; mdl_flash = 0;
    endtask

    task automatic model_step(input bit tk, input bit sm, input bit ss, input bit st, input bit cl);
        int total;
        total = mdl_min * 60 + mdl_sec;
        if (cl) begin
            model_reset();
        end else if (mdl_mode == 0 || mdl_mode == 2) begin
            if (st) begin
                mdl_mode = (total != 0) ? 1 : 0;
            end else begin
                if (sm) mdl_min = (mdl_min + 1) % 60;
                if (ss) mdl_sec = (mdl_sec + 1) % 60;
            end
        end else if (mdl_mode == 1) begin
            if (tk) begin
                total = total - 1;
                mdl_min = total / 60;
                mdl_sec = total % 60;
            end
            if (tk && total == 0) begin
                mdl_mode = 3; mdl_acnt = 0; mdl_flash = 0;
            end else if (st) begin
                mdl_mode = 2;
            end
        end else begin
            if (st || (tk && mdl_acnt == ALARM_TICKS - 1)) begin
                mdl_mode = 0; mdl_flash = 0; mdl_acnt = 0;
            end else if (tk) begin
                mdl_flash = !mdl_flash;
                mdl_acnt++;
            end
        end
    endtask

    function automatic logic [17:0] model_outputs();
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'(mdl_min / 10); d2 = 4'(mdl_min % 10);
        d1 = 4'(mdl_sec / 10); d0 = 4'(mdl_sec % 10);
        if (mdl_min < 10) d3 = 4'hF;
        if (mdl_mode == 3 && mdl_flash) begin
            d3 = 4'hF; d2 = 4'hF; d1 = 4'hF; d0 = 4'hF;
        end
        return {d3, d2, d1, d0, (mdl_mode == 1), (mdl_mode == 3)};
    endfunction

    // drive one cycle of inputs, let the edge happen, sample 1 time unit later
    task automatic step(input bit tk, input bit sm, input bit ss, input bit st, input bit cl);
        tick = tk; set_min = sm; set_sec = ss; start_stop = st; clear = cl;
        @(posedge clk);
        #1;
        tick = 0; set_min = 0; set_sec = 0; start_stop = 0; clear = 0;
        model_step(tk, sm, ss, st, cl);
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        #12;
        checks++;
        if ({dig3, dig2, dig1, dig0} !== 16'hF000) begin
            errors++;
            $display("FAIL reset_digits: got %h expected F000", {dig3, dig2, dig1, dig0});
        end
        checks++;
        if ({running, alarm} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got running=%b alarm=%b expected 0 0", running, alarm);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_load();
        repeat (3) step(0, 1, 0, 0, 0);
        repeat (5) step(0, 0, 1, 0, 0);
        checks++;
        if ({dig3, dig2, dig1, dig0, running} !== {16'hF305, 1'b0}) begin
            errors++;
            $display("FAIL load_03_05: got %h run=%b expected F305 run=0", {dig3, dig2, dig1, dig0}, running);
        end
    endtask

    task automatic test_borrow();
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        checks++;
        if ({dig3, dig2, dig1, dig0, running} !== {16'hF059, 1'b1}) begin
            errors++;
            $display("FAIL minute_borrow: got %h run=%b expected F059 run=1", {dig3, dig2, dig1, dig0}, running);
        end
    endtask

    task automatic test_alarm();
        step(0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++;
        if ({dig3, dig2, dig1, dig0, running, alarm} !== {16'hF000, 2'b01}) begin
            errors++;
            $display("FAIL alarm_entry: got %h run=%b alarm=%b expected F000 0 1", {dig3, dig2, dig1, dig0}, running, alarm);
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if ({dig3, dig2, dig1, dig0, alarm} !== {16'hFFFF, 1'b1}) begin
            errors++;
            $display("FAIL alarm_flash_on: got %h alarm=%b expected FFFF 1", {dig3, dig2, dig1, dig0}, alarm);
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if ({dig3, dig2, dig1, dig0, alarm} !== {16'hF000, 1'b1}) begin
            errors++;
            $display("FAIL alarm_flash_off: got %h alarm=%b expected F000 1", {dig3, dig2, dig1, dig0}, alarm);
        end
        repeat (ALARM_TICKS - 3) step(1, 0, 0, 0, 0);
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_hold_9_ticks: got alarm=%b expected 1", alarm);
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if ({dig3, dig2, dig1, dig0, running, alarm} !== {16'hF000, 2'b00}) begin
            errors++;
            $display("FAIL alarm_timeout: got %h run=%b alarm=%b expected F000 0 0", {dig3, dig2, dig1, dig0}, running, alarm);
        end
    endtask

    task automatic test_pause_tick();
        step(0, 0, 0, 0, 1);
        repeat (10) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        checks++;
        if ({dig3, dig2, dig1, dig0, running} !== {16'hF009, 1'b0}) begin
            errors++;
            $display("FAIL pause_with_tick: got %h run=%b expected F009 run=0", {dig3, dig2, dig1, dig0}, running);
        end
        repeat (2) step(0, 0, 1, 0, 0);
        checks++;
        if ({dig3, dig2, dig1, dig0} !== 16'hF011) begin
            errors++;
            $display("FAIL pause_edit: got %h expected F011", {dig3, dig2, dig1, dig0});
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume: got running=%b expected 1", running);
        end
    endtask

    task automatic test_idle_zero_and_wrap();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        checks++;
        if ({running, dig3, dig2, dig1, dig0} !== {1'b0, 16'hF000}) begin
            errors++;
            $display("FAIL start_at_zero: got run=%b %h expected 0 F000", running, {dig3, dig2, dig1, dig0});
        end
        repeat (2) step(0, 1, 0, 0, 0);
        repeat (60) step(0, 0, 1, 0, 0);
        checks++;
        if ({dig3, dig2, dig1, dig0} !== 16'hF200) begin
            errors++;
            $display("FAIL sec_wrap_60: got %h expected F200", {dig3, dig2, dig1, dig0});
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 0, 1);
        repeat (12) step(0, 1, 0, 0, 0);
        repeat (34) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        checks++;
        if ({dig3, dig2, dig1, dig0, running} !== {16'h1234, 1'b1}) begin
            errors++;
            $display("FAIL run_12_34: got %h run=%b expected 1234 run=1", {dig3, dig2, dig1, dig0}, running);
        end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if ({dig3, dig2, dig1, dig0, running} !== {16'hF000, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %h run=%b expected F000 run=0", {dig3, dig2, dig1, dig0}, running);
        end
        @(negedge clk);
        rst_n = 1;
        repeat (3) step(1, 0, 0, 0, 0);
        checks++;
        if ({dig3, dig2, dig1, dig0, running, alarm} !== {16'hF000, 2'b00}) begin
            errors++;
            $display("FAIL tick_after_reset: got %h run=%b alarm=%b expected F000 0 0", {dig3, dig2, dig1, dig0}, running, alarm);
        end
    endtask

    task automatic test_random();
        logic [17:0] exp_v;
        bit tk, sm, ss, st, cl;
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            tk = ($urandom_range(0, 3) == 0);
            sm = ($urandom_range(0, 9) == 0);
            ss = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 11) == 0);
            cl = ($urandom_range(0, 199) == 0);
            step(tk, sm, ss, st, cl);
            exp_v = model_outputs();
            checks++;
            if ({dig3, dig2, dig1, dig0, running, alarm} !== exp_v) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %h/%b%b expected %h/%b%b", i,
                         {dig3, dig2, dig1, dig0}, running, alarm, exp_v[17:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_borrow();
        test_alarm();
        test_pause_tick();
        test_idle_zero_and_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
